// File: rtl/tia_audio.sv
// tia_audio: TIA-style polynomial-counter audio generator with AUDC/AUDF/AUDV decode, PCM mix and per-channel PDM.
// Latency: register writes land on the next clk_i edge; chan_o/pcm_o are registered and move the cycle after a step.
// Backpressure: none; writes are always accepted and all outputs are free-running.
// Ports: clk_i/rst_i clock and synchronous active-high reset;
//        cpu_enable_i/stb_i/we_i/adr_i/dat_i register write bus shared with the TIA;
//        tick_o audio-rate pulse; chan_o raw channel bits; pcm_o mixed level; pdm_o sigma-delta bits.
module tia_audio #(
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 7,
  parameter int AUD_BASE     = 'h15,
  parameter int CLK_DIV      = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cpu_enable_i,
  input  logic                                stb_i,
  input  logic                                we_i,
  input  logic [ADDR_WIDTH-1:0]               adr_i,
  input  logic [7:0]                          dat_i,
  output logic                                tick_o,
  output logic [NUM_CHANNELS-1:0]             chan_o,
  output logic [4+$clog2(NUM_CHANNELS+1)-1:0] pcm_o,
  output logic [NUM_CHANNELS-1:0]             pdm_o
);
  localparam int PCM_W  = 4 + $clog2(NUM_CHANNELS + 1);
  localparam int PCNT_W = $clog2(CLK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);

  logic [PCNT_W-1:0]            pcnt_q, pcnt_d;
  logic                         tick;
  logic                         wr;
  logic [NUM_CHANNELS-1:0][3:0] lvl_nxt;
  logic [PCM_W-1:0]             pcm_q, pcm_d;
  logic                         unused_dat;

  // AUDF only holds five bits; the top data bits are never stored.
  assign unused_dat = ^dat_i[7:5];

  assign wr     = cpu_enable_i && stb_i && we_i && !rst_i;
  assign tick   = (pcnt_q == PCNT_LAST);
  assign tick_o = tick;
  assign pcm_o  = pcm_q;

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
  end

  // Mix from next-state channel bits and volumes so pcm_o always agrees
  // with chan_o and the live AUDV values in the same cycle.
  always_comb begin
    pcm_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pcm_d = pcm_d + PCM_W'(lvl_nxt[c]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
      pcm_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      pcm_q  <= pcm_d;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    localparam logic [ADDR_WIDTH-1:0] ADR_C = ADDR_WIDTH'(AUD_BASE + c);
    localparam logic [ADDR_WIDTH-1:0] ADR_F = ADDR_WIDTH'(AUD_BASE + NUM_CHANNELS + c);
    localparam logic [ADDR_WIDTH-1:0] ADR_V = ADDR_WIDTH'(AUD_BASE + 2 * NUM_CHANNELS + c);

    logic [3:0] audc_q, audc_d;
    logic [4:0] audf_q, audf_d;
    logic [3:0] audv_q, audv_d;
    logic [4:0] fcnt_q, fcnt_d;
    logic [3:0] p4_q, p4_d;
    logic [4:0] p5_q, p5_d;
    logic [8:0] p9_q, p9_d;
    logic [1:0] div3_q, div3_d;
    logic [4:0] d31_q, d31_d;
    logic       t_q, t_d;
    logic       chan_q, chan_d;
    logic [4:0] acc_q, acc_d;

    logic       step;
    logic       div3_wrap;
    logic       d31_adv;
    logic       d31_wrap;
    logic       p4_sh;
    logic       p5_sh;
    logic       t_tog;
    logic       out;
    logic [3:0] level;

    always_comb begin
      audc_d = (wr && adr_i == ADR_C) ? dat_i[3:0] : audc_q;
      audf_d = (wr && adr_i == ADR_F) ? dat_i[4:0] : audf_q;
      audv_d = (wr && adr_i == ADR_V) ? dat_i[3:0] : audv_q;

      // >= rather than == so lowering AUDF below fcnt steps on the next tick.
      step   = tick && (fcnt_q >= audf_q);
      fcnt_d = fcnt_q;
      if (tick) begin
        fcnt_d = step ? 5'd0 : fcnt_q + 5'd1;
      end

      div3_wrap = (div3_q == 2'd2);
      d31_adv   = (audc_q == 4'd14) ? div3_wrap : 1'b1;
      d31_wrap  = d31_adv && (d31_q == 5'd30);

      case (audc_q)
        4'd2:    p4_sh = d31_wrap;
        4'd3:    p4_sh = p5_q[4];
        default: p4_sh = 1'b1;
      endcase
      p5_sh = (audc_q == 4'd15) ? div3_wrap : 1'b1;

      case (audc_q)
        4'd4, 4'd5:   t_tog = 1'b1;
        4'd12, 4'd13: t_tog = div3_wrap;
        default:      t_tog = 1'b0;
      endcase

      div3_d = div3_q;
      d31_d  = d31_q;
      p4_d   = p4_q;
      p5_d   = p5_q;
      p9_d   = p9_q;
      t_d    = t_q;
      if (step) begin
        div3_d = div3_wrap ? 2'd0 : div3_q + 2'd1;
        if (d31_adv) begin
          d31_d = d31_wrap ? 5'd0 : d31_q + 5'd1;
        end
        if (p4_sh) begin
          p4_d = {p4_q[2:0], p4_q[3] ^ p4_q[2]};
        end
        if (p5_sh) begin
          p5_d = {p5_q[3:0], p5_q[4] ^ p5_q[2]};
        end
        p9_d = {p9_q[7:0], p9_q[8] ^ p9_q[4]};
        t_d  = t_q ^ t_tog;
      end

      // Waveform is taken from the post-step state; the tick's AUDC (old value) selects it.
      case (audc_q)
        4'd1, 4'd2, 4'd3:           out = p4_d[3];
        4'd4, 4'd5, 4'd12, 4'd13:   out = t_d;
        4'd6, 4'd10, 4'd14:         out = (d31_d < 5'd13);
        4'd7, 4'd9, 4'd15:          out = p5_d[4];
        4'd8:                       out = p9_d[8];
        default:                    out = 1'b1;
      endcase
      chan_d = step ? out : chan_q;

      // First-order sigma-delta: the carry out of a 4-bit accumulator is the pulse.
      level = chan_q ? audv_q : 4'd0;
      acc_d = {1'b0, acc_q[3:0]} + {1'b0, level};
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        audc_q <= '0;
        audf_q <= '0;
        audv_q <= '0;
        fcnt_q <= '0;
        p4_q   <= 4'hF;
        p5_q   <= 5'h1F;
        p9_q   <= 9'h1FF;
        div3_q <= '0;
        d31_q  <= '0;
        t_q    <= 1'b0;
        chan_q <= 1'b1;
        acc_q  <= '0;
      end else begin
        audc_q <= audc_d;
        audf_q <= audf_d;
        audv_q <= audv_d;
        fcnt_q <= fcnt_d;
        p4_q   <= p4_d;
        p5_q   <= p5_d;
        p9_q   <= p9_d;
        div3_q <= div3_d;
        d31_q  <= d31_d;
        t_q    <= t_d;
        chan_q <= chan_d;
        acc_q  <= acc_d;
      end
    end

    assign chan_o[c]  = chan_q;
    assign pdm_o[c]   = acc_q[4];
    assign lvl_nxt[c] = chan_d ? audv_d : 4'd0;
  end

endmodule

// File: tb/tb_tia_audio.sv
// tb_tia_audio: randomized scoreboard bench for tia_audio against a behavioural channel model.
// Latency: expected outputs are queued per tick and checked the cycle after that tick.
// Backpressure: none; the monitor pops one entry for every tick_o the design presents.
module tb_tia_audio;
  localparam int N    = 2;
  localparam int AW   = 7;
  localparam int BASE = 'h15;
  localparam int CD   = 4;
  localparam int PW   = 4 + $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [7:0]    dat;
  logic          tick_o;
  logic [N-1:0]  chan_o;
  logic [PW-1:0] pcm_o;
  logic [N-1:0]  pdm_o;

  tia_audio #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .AUD_BASE(BASE), .CLK_DIV(CD)) dut (
    .clk_i(clk), .rst_i(rst), .cpu_enable_i(ce), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat), .tick_o(tick_o), .chan_o(chan_o), .pcm_o(pcm_o), .pdm_o(pdm_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    longint t;
    int     chan;
    int     pcm;
    int     pdm;
  } exp_t;
  exp_t sbq[$];

  // Reference model: plain integers, one entry per channel.
  int m_audc[N], m_audf[N], m_audv[N], m_fcnt[N];
  int m_p4[N], m_p5[N], m_p9[N], m_div3[N], m_d31[N], m_t[N], m_chan[N], m_acc[N];
  int m_pcnt;

  function automatic int bit_of(input int v, input int b);
    return (v >> b) & 1;
  endfunction

  task automatic m_reset();
    m_pcnt = 0;
    for (int c = 0; c < N; c++) begin
      m_audc[c] = 0; m_audf[c] = 0; m_audv[c] = 0; m_fcnt[c] = 0;
      m_p4[c] = 15; m_p5[c] = 31; m_p9[c] = 511;
      m_div3[c] = 0; m_d31[c] = 0; m_t[c] = 0; m_chan[c] = 1; m_acc[c] = 0;
    end
  endtask

  task automatic m_step(input int c);
    int a, w3, adv31, w31, sh4, sh5, tog;
    a     = m_audc[c];
    w3    = (m_div3[c] == 2) ? 1 : 0;
    adv31 = (a == 14) ? w3 : 1;
    w31   = (adv31 == 1 && m_d31[c] == 30) ? 1 : 0;
    sh4   = (a == 2) ? w31 : ((a == 3) ? bit_of(m_p5[c], 4) : 1);
    sh5   = (a == 15) ? w3 : 1;
    tog   = (a == 4 || a == 5) ? 1 : ((a == 12 || a == 13) ? w3 : 0);
    m_div3[c] = (m_div3[c] + 1) % 3;
    if (adv31 != 0) m_d31[c] = (m_d31[c] + 1) % 31;
    if (sh4 != 0) m_p4[c] = ((m_p4[c] * 2) % 16) + (bit_of(m_p4[c], 3) ^ bit_of(m_p4[c], 2));
    if (sh5 != 0) m_p5[c] = ((m_p5[c] * 2) % 32) + (bit_of(m_p5[c], 4) ^ bit_of(m_p5[c], 2));
    m_p9[c] = ((m_p9[c] * 2) % 512) + (bit_of(m_p9[c], 8) ^ bit_of(m_p9[c], 4));
    m_t[c]  = m_t[c] ^ tog;
    case (a)
      1, 2, 3:        m_chan[c] = bit_of(m_p4[c], 3);
      4, 5, 12, 13:   m_chan[c] = m_t[c];
      6, 10, 14:      m_chan[c] = (m_d31[c] < 13) ? 1 : 0;
      7, 9, 15:       m_chan[c] = bit_of(m_p5[c], 4);
      8:              m_chan[c] = bit_of(m_p9[c], 8);
      default:        m_chan[c] = 1;
    endcase
  endtask

  // One clock cycle: drive inputs at the falling edge and advance the model
  // through the rising edge that follows.
  task automatic cycle(input bit r, input bit e, input bit s, input bit w, input int a, input int d);
    int   tk, off;
    exp_t it;
    @(negedge clk);
    rst = r; ce = e; stb = s; we = w; adr = AW'(a); dat = 8'(d);
    tk = (m_pcnt == CD - 1) ? 1 : 0;
    if (r) begin
      m_reset();
    end else begin
      for (int c = 0; c < N; c++) begin
        m_acc[c] = (m_acc[c] % 16) + ((m_chan[c] != 0) ? m_audv[c] : 0);
      end
      if (tk != 0) begin
        for (int c = 0; c < N; c++) begin
          if (m_fcnt[c] >= m_audf[c]) begin
            m_fcnt[c] = 0;
            m_step(c);
          end else begin
            m_fcnt[c]++;
          end
        end
      end
      if (e && s && w) begin
        off = a - BASE;
        if (off >= 0 && off < 3 * N) begin
          case (off / N)
            0:       m_audc[off % N] = d % 16;
            1:       m_audf[off % N] = d % 32;
            default: m_audv[off % N] = d % 16;
          endcase
        end
      end
      m_pcnt = (m_pcnt + 1) % CD;
    end
    if (tk != 0) begin
      it.t = longint'($time); it.chan = 0; it.pcm = 0; it.pdm = 0;
      for (int c = 0; c < N; c++) begin
        it.chan += m_chan[c] << c;
        it.pcm  += (m_chan[c] != 0) ? m_audv[c] : 0;
        it.pdm  += ((m_acc[c] >= 16) ? 1 : 0) << c;
      end
      sbq.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wr_reg(input int a, input int d);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  // Monitor: a tick seen in one cycle means that tick's results are visible in the next.
  bit     mon_pend = 1'b0;
  longint mon_t = 0;
  exp_t   mon_it;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_tick: tick at t=%0d, nothing expected", mon_t);
        end else begin
          mon_it = sbq.pop_front();
          chk("sb_tick_time", int'(mon_t), int'(mon_it.t));
          chk("sb_chan", int'(chan_o), mon_it.chan);
          chk("sb_pcm", int'(pcm_o), mon_it.pcm);
          chk("sb_pdm", int'(pdm_o), mon_it.pdm);
        end
      end
      mon_pend = (tick_o === 1'b1);
      mon_t    = longint'($time);
    end
  end

  task automatic period_check(input string nm, input int mode, input int per, input int ones);
    int s[$];
    int bad = 0;
    int one = 0;
    wr_reg('h15, mode);
    wr_reg('h17, 0);
    idle(8);
    for (int k = 0; k < 2 * per; k++) begin
      idle(CD);
      s.push_back(int'(chan_o[0]));
    end
    for (int k = 0; k < per; k++) begin
      if (s[k] != s[k + per]) bad++;
      one += s[k];
    end
    chk({nm, "_period"}, bad, 0);
    chk({nm, "_ones"}, one, ones);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks, bad, prev, cur, guard, c0, p0, p1, a, d;
    rst = 1'b1; ce = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
    m_reset();

    // Reset state and prescaler rate.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(1);
    chk("rst_pcm", int'(pcm_o), 0);
    chk("rst_pdm", int'(pdm_o), 0);
    chk("rst_chan", int'(chan_o), 3);
    chk("rst_tick", int'(tick_o), 0);
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      ticks += int'(tick_o);
    end
    chk("tick_rate", ticks, 40 / CD);

    // Writes that must not land anywhere.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 'h19, 15);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 'h15, 4);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 'h14, 'hff);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 'h1b, 'hff);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 'h19, 15);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 'h19, 15);
    idle(12);
    chk("decode_pcm", int'(pcm_o), 0);
    chk("decode_chan", int'(chan_o), 3);

    // Pure tone: pcm toggles between 0 and 15 once per tick.
    wr_reg('h15, 4);
    wr_reg('h17, 0);
    wr_reg('h19, 15);
    idle(6);
    bad = 0;
    prev = int'(pcm_o);
    for (int k = 0; k < 8; k++) begin
      idle(CD);
      cur = int'(pcm_o);
      if (cur == prev || (cur != 0 && cur != 15)) bad++;
      prev = cur;
    end
    chk("tone_alternate", bad, 0);

    // Polynomial periods and duty.
    period_check("poly4", 1, 15, 8);
    period_check("poly5", 7, 31, 16);
    period_check("poly9", 8, 511, 256);

    // Divider: AUDF=3, then drop AUDF to 0 while fcnt sits at 2.
    wr_reg('h15, 4);
    wr_reg('h17, 3);
    idle(40);
    guard = 0;
    while (m_fcnt[0] != 2 && guard < 200) begin
      idle(1);
      guard++;
    end
    chk("div_fcnt_reached", (guard < 200) ? 1 : 0, 1);
    c0 = int'(chan_o[0]);
    wr_reg('h17, 0);
    idle(4);
    chk("div_rewrite_step", int'(chan_o[0]), 1 - c0);

    // Random register traffic, occasional reset with a write in the same cycle.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = int'($urandom_range('h13, 'h1c));
        d = int'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) d = d & 'he3;
        cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, 1'b1,
              $urandom_range(0, 7) != 0, a, d);
      end else begin
        idle(1);
      end
    end

    // Mix and PDM density.
    wr_reg('h15, 0);
    wr_reg('h16, 0);
    wr_reg('h17, 0);
    wr_reg('h18, 0);
    wr_reg('h19, 15);
    wr_reg('h1a, 9);
    idle(12);
    chk("mix_pcm", int'(pcm_o), 24);
    chk("mix_chan", int'(chan_o), 3);
    p0 = 0;
    p1 = 0;
    for (int k = 0; k < 16; k++) begin
      idle(1);
      p0 += int'(pdm_o[0]);
      p1 += int'(pdm_o[1]);
    end
    chk("pdm0_density", p0, 15);
    chk("pdm1_density", p1, 9);

    // Reset during tone generation, with a write that must be dropped.
    wr_reg('h15, 4);
    idle(10);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 'h1a, 7);
    idle(1);
    chk("midrst_pcm", int'(pcm_o), 0);
    chk("midrst_pdm", int'(pdm_o), 0);
    chk("midrst_chan", int'(chan_o), 3);
    chk("midrst_tick", int'(tick_o), 0);
    idle(12);
    chk("midrst_write_dropped", int'(pcm_o), 0);

    idle(4);
    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tia_audio.md
# tia_audio

Parametrised TIA-style audio generator for the 2600 core. It replaces the fixed square-wave dividers with per-channel polynomial-counter tone generation driven by AUDCx, AUDFx and AUDVx, and supports a configurable channel count. It decodes the AUDC/AUDF/AUDV register writes from the same CPU write strobe as the TIA, produces a mixed PCM level for DAC/HDMI audio, and drives one first-order sigma-delta bit per channel for the board's audio pins.

## Interface
- NUM_CHANNELS, 2: number of independent channels (1..8).
- ADDR_WIDTH, 7: register address width.
- AUD_BASE, 'h15: address of AUDC for channel 0.
- CLK_DIV, 64: clk_i cycles per audio tick (≥2).
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- cpu_enable_i  in  1  qualifies register writes.
- stb_i  in  1  bus strobe.
- we_i  in  1  write enable.
- adr_i  in  ADDR_WIDTH  register address.
- dat_i  in  8  write data.
- tick_o  in/out: out  1  one-cycle audio tick pulse.
- chan_o  out  NUM_CHANNELS  raw per-channel waveform bit.
- pcm_o  out  4+$clog2(NUM_CHANNELS+1)  mixed level.
- pdm_o  out  NUM_CHANNELS  per-channel sigma-delta bit.

## Operation
- Write decode: a write occurs when cpu_enable_i && stb_i && we_i && !rst_i. Register r (0=AUDC, 1=AUDF, 2=AUDV) of channel c is at AUD_BASE + r*NUM_CHANNELS + c. AUDC and AUDV take dat_i[3:0]; AUDF takes dat_i[4:0]. Other addresses are ignored. With NUM_CHANNELS=2 this gives 0x15–0x1a.
- Prescaler: pcnt counts 0..CLK_DIV-1. tick_o=1 for the single cycle where pcnt==CLK_DIV-1.
- Frequency divider, per channel, on tick: if fcnt ≥ AUDF, then fcnt←0 and step=1; else fcnt←fcnt+1. Step rate is tick/(AUDF+1). Using ≥ means an AUDF write below fcnt steps on the next tick.
- On step, each channel maintains:
  - poly4: next = {p[2:0], p[3]^p[2]}, output p[3].
  - poly5: next = {p[3:0], p[4]^p[2]}.
  - poly9: next = {p[7:0], p[8]^p[4]}.
  - div3 counter: 0..2.
  - d31 counter: 0..30.
  - tone flip-flop t.
- Modes, selected by AUDC:
  - 0, 11: out=1.
  - 1: out=poly4; poly4 shifts every step.
  - 2: poly4 shifts only on steps where d31 wraps to 0.
  - 3: poly4 shifts only on steps where poly5 bit4 is 1; poly5 always shifts.
  - 4, 5: t toggles every step.
  - 6, 10: out = (d31 < 13).
  - 7, 9: out = poly5 bit4.
  - 8: out = poly9 bit8.
  - 12, 13: t toggles when div3 wraps.
  - 14: d31 advances only when div3 wraps; out = (d31 < 13).
  - 15: poly5 shifts only when div3 wraps; out = poly5 bit4.
  - Counters not used by the current mode still advance on every step.
- Mix: pcm_o = Σ (chan_o[c] ? AUDV[c] : 0).
- PDM, per channel, every clk_i: acc(5b) ← acc[3:0] + level, where level = chan_o[c] ? AUDV[c] : 0. pdm_o[c] = acc[4].

## Timing
- Reset values:
  - AUDC, AUDF, AUDV, fcnt, pcnt, div3, d31, t, acc: 0.
  - LFSRs: all ones (poly4 4'hF, poly5 5'h1F, poly9 9'h1FF).
  - Outputs: tick_o=0; pcm_o=0; pdm_o=0; chan_o=1 under the reset default AUDC=0, but pcm_o=0 because AUDV=0.
- The first tick_o is CLK_DIV cycles after rst_i deasserts.
- A register write is visible in state on the next clk_i edge. Its effect on chan_o appears at the next step; an AUDV change appears in pcm_o on the next edge.
- chan_o and pcm_o are registered: they update the cycle after the tick in which the step occurred.
- An AUDC change does not reset counters or LFSRs.
- Reset mid-operation returns everything to the reset values in one edge. A write in the same cycle as reset is dropped.
- Simultaneous write and tick: the tick uses the old value; the new value takes effect from the next cycle.
- LFSRs never reach all zeros from reset.

## Test plan
- Reset: after rst_i, pcm_o=0, pdm_o=0, tick_o pulses every CLK_DIV=4 cycles.
- Pure tone: write 0x15←4, 0x17←0, 0x19←15 with CLK_DIV=4. chan_o[0] toggles every 4 cycles; pcm_o alternates 0/15, starting at 15 after the first step.
- Polynomials:
  - AUDC=1, AUDF=0: chan_o[0] sequence repeats with period 15 ticks, eight ones per period.
  - AUDC=8: period 511 ticks.
  - AUDC=7: period 31 ticks.
- Divider: AUDC=4, AUDF=3 gives one toggle per 4 ticks. Rewriting AUDF to 0 while fcnt=2 steps on the next tick.
- Mix and PDM: two channels with AUDC=0, AUDV=15 and 9 give pcm_o=24. Over 16 cycles, pdm_o[1] is high exactly 9 times and pdm_o[0] 15 times.
- Decode: writes with cpu_enable_i=0, or to 0x14 and 0x1b, change no state. Asserting rst_i during tone generation restores all reset values on the next edge.
